// File: rtl/data_bus_master.sv
// data_bus_master: CPU load/store front end for the shared tri-state data bus.
// Loads take one stall cycle, stores complete in one cycle, and bad requests raise a sticky fault.
module data_bus_master #(
  parameter logic [31:0] FLASH_TOP  = 32'h0000_3000,
  parameter logic [1:0]  MODE_READ  = 2'b01,
  parameter logic [1:0]  MODE_WRITE = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        stall_lw,
  output logic [31:0] data_bus_addr,
  output logic [1:0]  data_bus_mode,
  output logic [1:0]  data_bus_reqw,
  output logic        data_bus_reqs,
  inout  wire  logic [31:0] data_bus_data,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic [4:0]  load_rd,
  output logic        fault_valid,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  input  logic        fault_clear
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] W_WORD    = 2'b00;
  localparam logic [1:0] W_HALF    = 2'b01;
  localparam logic [1:0] W_BYTE    = 2'b10;
  localparam logic [1:0] W_RSVD    = 2'b11;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_LD_MIS = 2'b01;
  localparam logic [1:0] CAUSE_ST_MIS = 2'b10;
  localparam logic [1:0] CAUSE_FLASH  = 2'b11;

  function automatic logic [1:0] norm_width(input logic [1:0] w);
    case (w)
      W_RSVD:  return W_WORD;
      default: return w;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] w, input logic [1:0] a);
    case (w)
      W_HALF:  return (a == 2'b11);
      W_BYTE:  return 1'b0;
      default: return (a != 2'b00);
    endcase
  endfunction

  logic [0:0]  state_r;
  logic [0:0]  next_state_s;
  logic [31:0] lat_addr_r;
  logic [1:0]  lat_width_r;
  logic        lat_signed_r;
  logic [4:0]  lat_rd_r;
  logic        fault_valid_r;
  logic [1:0]  fault_cause_r;
  logic [31:0] fault_addr_r;

  logic [1:0]  width_s;
  logic        misaligned_s;
  logic        idle_req_s;
  logic        fault_s;
  logic [1:0]  fault_cause_s;
  logic        load_acc_s;
  logic        store_acc_s;
  logic        drive_s;

  // Classify a request seen in IDLE; misalignment outranks the flash-store check.
  always_comb begin
    width_s       = norm_width(req_width);
    misaligned_s  = is_misaligned(width_s, req_addr[1:0]);
    idle_req_s    = reset && (state_r == ST_IDLE) && req_valid;
    fault_s       = 1'b0;
    fault_cause_s = CAUSE_NONE;
    load_acc_s    = 1'b0;
    store_acc_s   = 1'b0;
    if (!idle_req_s) begin
      fault_s = 1'b0;
    end else if (misaligned_s) begin
      fault_s       = 1'b1;
      fault_cause_s = req_write ? CAUSE_ST_MIS : CAUSE_LD_MIS;
    end else if (req_write && (req_addr < FLASH_TOP)) begin
      fault_s       = 1'b1;
      fault_cause_s = CAUSE_FLASH;
    end else if (req_write) begin
      store_acc_s = 1'b1;
    end else begin
      load_acc_s = 1'b1;
    end
  end

  // Bus, stall and load-result outputs; reset gates everything back to idle values.
  always_comb begin
    next_state_s  = ST_IDLE;
    stall         = 1'b0;
    stall_lw      = 1'b0;
    data_bus_addr = 32'h0000_0000;
    data_bus_mode = MODE_IDLE;
    data_bus_reqw = W_WORD;
    data_bus_reqs = 1'b0;
    load_valid    = 1'b0;
    load_data     = 32'h0000_0000;
    load_rd       = 5'd0;
    drive_s       = 1'b0;
    if (reset && (state_r == ST_LOAD)) begin
      data_bus_addr = lat_addr_r;
      data_bus_mode = MODE_READ;
      data_bus_reqw = lat_width_r;
      data_bus_reqs = lat_signed_r;
      load_valid    = 1'b1;
      load_data     = data_bus_data;
      load_rd       = lat_rd_r;
      stall         = req_valid;
      next_state_s  = ST_IDLE;
    end else if (load_acc_s) begin
      data_bus_addr = req_addr;
      data_bus_mode = MODE_READ;
      data_bus_reqw = width_s;
      data_bus_reqs = req_signed;
      stall         = 1'b1;
      stall_lw      = 1'b1;
      next_state_s  = ST_LOAD;
    end else if (store_acc_s) begin
      data_bus_addr = req_addr;
      data_bus_mode = MODE_WRITE;
      data_bus_reqw = width_s;
      drive_s       = 1'b1;
      next_state_s  = ST_IDLE;
    end else begin
      next_state_s = ST_IDLE;
    end
  end

  assign data_bus_data = drive_s ? req_wdata : 32'bz;

  // FSM state and the fields of an accepted load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      lat_addr_r   <= 32'h0000_0000;
      lat_width_r  <= W_WORD;
      lat_signed_r <= 1'b0;
      lat_rd_r     <= 5'd0;
    end else begin
      state_r <= next_state_s;
      if (load_acc_s) begin
        lat_addr_r   <= req_addr;
        lat_width_r  <= width_s;
        lat_signed_r <= req_signed;
        lat_rd_r     <= req_rd;
      end
    end
  end

  // Sticky fault record: first fault wins, and a new fault beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_valid_r <= 1'b0;
      fault_cause_r <= CAUSE_NONE;
      fault_addr_r  <= 32'h0000_0000;
    end else if (fault_s) begin
      fault_valid_r <= 1'b1;
      if (!fault_valid_r) begin
        fault_cause_r <= fault_cause_s;
        fault_addr_r  <= req_addr;
      end
    end else if (fault_clear) begin
      fault_valid_r <= 1'b0;
    end
  end

  assign fault_valid = fault_valid_r;
  assign fault_cause = fault_cause_r;
  assign fault_addr  = fault_addr_r;

endmodule

// File: tb/tb_data_bus_master.sv
// Self-checking bench for data_bus_master: directed scenarios plus randomized traffic
// compared against a pending-load / sticky-fault reference model and a byte-memory responder.
module tb_data_bus_master;
  localparam logic [31:0] FLASH_TOP  = 32'h0000_3000;
  localparam logic [1:0]  MODE_READ  = 2'b01;
  localparam logic [1:0]  MODE_WRITE = 2'b10;

  logic        clk;
  logic        reset;
  logic        req_valid, req_write, req_signed, fault_clear;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_width;
  logic [4:0]  req_rd;
  logic        stall, stall_lw, data_bus_reqs, load_valid, fault_valid;
  logic [31:0] data_bus_addr, load_data, fault_addr;
  logic [1:0]  data_bus_mode, data_bus_reqw, fault_cause;
  logic [4:0]  load_rd;
  wire  [31:0] data_bus_data;
  logic [31:0] resp_data;

  logic [7:0]  mem [0:65535];
  int          n_checks, n_errors;

  // reference model state
  logic        m_live, m_pend, m_psigned, m_fv;
  logic [31:0] m_paddr, m_fa;
  logic [1:0]  m_pwidth, m_fc;
  logic [4:0]  m_prd;
  // per-cycle expectations
  logic [1:0]  e_mode, e_reqw, e_fcause;
  logic [31:0] e_addr, e_ld, e_bus;
  logic        e_reqs, e_stall, e_stall_lw, e_lv, e_fault, e_load_acc;
  logic [4:0]  e_lrd;

  data_bus_master #(.FLASH_TOP(FLASH_TOP), .MODE_READ(MODE_READ), .MODE_WRITE(MODE_WRITE)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
    .req_signed(req_signed), .req_rd(req_rd), .stall(stall), .stall_lw(stall_lw),
    .data_bus_addr(data_bus_addr), .data_bus_mode(data_bus_mode),
    .data_bus_reqw(data_bus_reqw), .data_bus_reqs(data_bus_reqs),
    .data_bus_data(data_bus_data), .load_valid(load_valid), .load_data(load_data),
    .load_rd(load_rd), .fault_valid(fault_valid), .fault_cause(fault_cause),
    .fault_addr(fault_addr), .fault_clear(fault_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte memory read with the responder's own width/sign handling.
  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] w, input logic s);
    int n;
    logic [31:0] r;
    logic [15:0] idx;
    n = (w == 2'b01) ? 2 : ((w == 2'b10) ? 1 : 4);
    r = 32'h0;
    for (int k = 0; k < n; k++) begin
      idx = a[15:0] + 16'(k);
      r = r | (32'(mem[idx]) << (8 * k));
    end
    if (n < 4 && s && r[8*n-1]) r = r | ~((32'h1 << (8 * n)) - 32'h1);
    return r;
  endfunction

  // Responder: answers reads, releases the bus for writes, otherwise holds it at zero.
  always_comb resp_data = (data_bus_mode == MODE_READ) ? mem_read(data_bus_addr, data_bus_reqw, data_bus_reqs) : 32'h0;
  assign data_bus_data = (data_bus_mode == MODE_WRITE) ? 32'bz : resp_data;

  task automatic model_reset();
    m_live = 1'b0; m_pend = 1'b0; m_paddr = 32'h0; m_pwidth = 2'b00; m_psigned = 1'b0;
    m_prd = 5'd0; m_fv = 1'b0; m_fc = 2'b00; m_fa = 32'h0;
  endtask

  task automatic model_eval();
    logic [1:0] ew;
    int unsigned off;
    logic mis;
    ew  = (req_width == 2'b11) ? 2'b00 : req_width;
    off = req_addr % 4;
    mis = (ew == 2'b00 && off != 0) || (ew == 2'b01 && off == 3);
    e_mode = 2'b00; e_addr = 32'h0; e_reqw = 2'b00; e_reqs = 1'b0; e_stall = 1'b0;
    e_stall_lw = 1'b0; e_lv = 1'b0; e_ld = 32'h0; e_lrd = 5'd0; e_bus = 32'h0;
    e_fault = 1'b0; e_fcause = 2'b00; e_load_acc = 1'b0;
    if (m_pend) begin
      e_mode = MODE_READ; e_addr = m_paddr; e_reqw = m_pwidth; e_reqs = m_psigned;
      e_lv = 1'b1; e_ld = mem_read(m_paddr, m_pwidth, m_psigned); e_lrd = m_prd;
      e_stall = req_valid;
    end else if (req_valid) begin
      if (mis) begin
        e_fault = 1'b1; e_fcause = req_write ? 2'b10 : 2'b01;
      end else if (req_write && req_addr < FLASH_TOP) begin
        e_fault = 1'b1; e_fcause = 2'b11;
      end else if (req_write) begin
        e_mode = MODE_WRITE; e_addr = req_addr; e_reqw = ew; e_bus = req_wdata;
      end else begin
        e_load_acc = 1'b1; e_mode = MODE_READ; e_addr = req_addr; e_reqw = ew;
        e_reqs = req_signed; e_stall = 1'b1; e_stall_lw = 1'b1;
      end
    end
  endtask

  task automatic model_commit();
    if (e_fault) begin
      if (!m_fv) begin m_fc = e_fcause; m_fa = req_addr; end
      m_fv = 1'b1;
    end else if (fault_clear) begin
      m_fv = 1'b0;
    end
    if (m_pend) begin
      m_pend = 1'b0;
    end else if (e_load_acc) begin
      m_pend = 1'b1; m_paddr = req_addr; m_pwidth = e_reqw; m_psigned = req_signed; m_prd = req_rd;
    end
  endtask

  // One bus cycle: drive at the falling edge, settle, then form expectations.
  task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] wid, input logic sg, input logic [4:0] rd, input logic fc);
    if (m_live) model_commit();
    @(negedge clk);
    req_valid = v; req_write = w; req_addr = a; req_wdata = wd;
    req_width = wid; req_signed = sg; req_rd = rd; fault_clear = fc;
    #1;
    model_eval();
    m_live = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4000; req_wdata = 32'h1234_5678;
    #2 reset = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_checks++; if (stall_lw !== 1'b0) begin n_errors++; $display("FAIL rst_stall_lw: got %b want 0", stall_lw); end
    n_checks++; if (load_valid !== 1'b0) begin n_errors++; $display("FAIL rst_load_valid: got %b want 0", load_valid); end
    n_checks++; if (data_bus_mode !== 2'b00) begin n_errors++; $display("FAIL rst_mode: got %b want 00", data_bus_mode); end
    n_checks++; if (data_bus_addr !== 32'h0) begin n_errors++; $display("FAIL rst_addr: got %h want 0", data_bus_addr); end
    n_checks++; if (data_bus_data !== 32'h0) begin n_errors++; $display("FAIL rst_bus: got %h want released", data_bus_data); end
    n_checks++; if ({fault_valid, fault_cause, fault_addr} !== 35'h0) begin n_errors++; $display("FAIL rst_fault: got %b/%b/%h want 0/00/0", fault_valid, fault_cause, fault_addr); end
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b1;
    model_reset();
  endtask

  task automatic test_load_word();
    mem[16'h0100] = 8'h78; mem[16'h0101] = 8'h56; mem[16'h0102] = 8'h34; mem[16'h0103] = 8'h12;
    drive(1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 1'b0, 5'd5, 1'b0);
    n_checks++; if ({stall, stall_lw} !== 2'b11) begin n_errors++; $display("FAIL lw_c0_stall: got %b%b want 11", stall, stall_lw); end
    n_checks++; if (data_bus_mode !== MODE_READ || data_bus_addr !== 32'h100) begin n_errors++; $display("FAIL lw_c0_bus: got %b/%h want 01/100", data_bus_mode, data_bus_addr); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
    n_checks++; if (load_valid !== 1'b1 || load_data !== 32'h1234_5678) begin n_errors++; $display("FAIL lw_c1_data: got %b/%h want 1/12345678", load_valid, load_data); end
    n_checks++; if (load_rd !== 5'd5 || {stall, stall_lw} !== 2'b00) begin n_errors++; $display("FAIL lw_c1_rd: got rd %0d stall %b%b want 5 00", load_rd, stall, stall_lw); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
    n_checks++; if (load_valid !== 1'b0 || data_bus_mode !== 2'b00) begin n_errors++; $display("FAIL lw_c2_idle: got %b/%b want 0/00", load_valid, data_bus_mode); end
  endtask

  task automatic test_signed_byte();
    mem[16'h0103] = 8'h80;
    drive(1'b1, 1'b0, 32'h103, 32'h0, 2'b10, 1'b1, 5'd9, 1'b0);
    n_checks++; if (stall !== 1'b1 || data_bus_reqs !== 1'b1 || data_bus_reqw !== 2'b10) begin n_errors++; $display("FAIL sb_c0: got stall %b reqs %b reqw %b want 1 1 10", stall, data_bus_reqs, data_bus_reqw); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
    n_checks++; if (load_valid !== 1'b1 || load_data !== 32'hFFFF_FF80 || load_rd !== 5'd9) begin n_errors++; $display("FAIL sb_c1_data: got %b/%h/%0d want 1/ffffff80/9", load_valid, load_data, load_rd); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL sb_c1_stall: got %b want 0", stall); end
  endtask

  task automatic test_store();
    drive(1'b1, 1'b1, 32'h4000, 32'hDEAD_BEEF, 2'b00, 1'b0, 5'd0, 1'b0);
    n_checks++; if (data_bus_mode !== MODE_WRITE || data_bus_data !== 32'hDEAD_BEEF || stall !== 1'b0) begin n_errors++; $display("FAIL st_c0: got %b/%h/%b want 10/deadbeef/0", data_bus_mode, data_bus_data, stall); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
    n_checks++; if (data_bus_mode !== 2'b00 || data_bus_data !== 32'h0) begin n_errors++; $display("FAIL st_c1_release: got %b/%h want 00/released", data_bus_mode, data_bus_data); end
  endtask

  task automatic test_fault();
    drive(1'b1, 1'b1, 32'h10, 32'h1111_1111, 2'b00, 1'b0, 5'd0, 1'b0);
    n_checks++; if (data_bus_mode !== 2'b00 || stall !== 1'b0) begin n_errors++; $display("FAIL flt_flash_bus: got %b/%b want 00/0", data_bus_mode, stall); end
    drive(1'b1, 1'b0, 32'h4001, 32'h0, 2'b00, 1'b0, 5'd1, 1'b0);
    n_checks++; if ({fault_valid, fault_cause, fault_addr} !== {1'b1, 2'b11, 32'h10}) begin n_errors++; $display("FAIL flt_set: got %b/%b/%h want 1/11/10", fault_valid, fault_cause, fault_addr); end
    n_checks++; if (data_bus_mode !== 2'b00 || stall !== 1'b0) begin n_errors++; $display("FAIL flt_mis_bus: got %b/%b want 00/0", data_bus_mode, stall); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b1);
    n_checks++; if ({fault_valid, fault_cause, fault_addr} !== {1'b1, 2'b11, 32'h10}) begin n_errors++; $display("FAIL flt_keep: got %b/%b/%h want 1/11/10", fault_valid, fault_cause, fault_addr); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
    n_checks++; if (fault_valid !== 1'b0) begin n_errors++; $display("FAIL flt_clear: got %b want 0", fault_valid); end
    drive(1'b1, 1'b0, 32'h4003, 32'h0, 2'b01, 1'b0, 5'd2, 1'b1);
    drive(1'b1, 1'b1, 32'h3000, 32'h5555_AAAA, 2'b00, 1'b0, 5'd0, 1'b0);
    n_checks++; if ({fault_valid, fault_cause, fault_addr} !== {1'b1, 2'b01, 32'h4003}) begin n_errors++; $display("FAIL flt_wins_clear: got %b/%b/%h want 1/01/4003", fault_valid, fault_cause, fault_addr); end
    n_checks++; if (data_bus_mode !== MODE_WRITE) begin n_errors++; $display("FAIL flt_flash_top_store: got %b want 10", data_bus_mode); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_ld;
    exp_ld = mem_read(32'h200, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 32'h200, 32'h0, 2'b00, 1'b0, 5'd3, 1'b0);
    n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL b2b_c0_stall: got %b want 1", stall); end
    drive(1'b1, 1'b1, 32'h5000, 32'hCAFE_F00D, 2'b00, 1'b0, 5'd0, 1'b0);
    n_checks++; if (stall !== 1'b1 || data_bus_mode !== MODE_READ) begin n_errors++; $display("FAIL b2b_c1_hold: got %b/%b want 1/01", stall, data_bus_mode); end
    n_checks++; if (load_valid !== 1'b1 || load_data !== exp_ld || load_rd !== 5'd3) begin n_errors++; $display("FAIL b2b_c1_load: got %b/%h/%0d want 1/%h/3", load_valid, load_data, load_rd, exp_ld); end
    drive(1'b1, 1'b1, 32'h5000, 32'hCAFE_F00D, 2'b00, 1'b0, 5'd0, 1'b0);
    n_checks++; if (stall !== 1'b0 || data_bus_mode !== MODE_WRITE || data_bus_data !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL b2b_c2_store: got %b/%b/%h want 0/10/cafef00d", stall, data_bus_mode, data_bus_data); end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_reset_during_load();
    drive(1'b1, 1'b1, 32'h20, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
    drive(1'b1, 1'b0, 32'h300, 32'h0, 2'b00, 1'b0, 5'd12, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    n_checks++; if (load_valid !== 1'b1 || fault_valid !== 1'b1) begin n_errors++; $display("FAIL rdl_pre: got %b/%b want 1/1", load_valid, fault_valid); end
    #1 reset = 1'b0;
    #1;
    n_checks++; if ({load_valid, stall, stall_lw, data_bus_mode} !== 5'b0) begin n_errors++; $display("FAIL rdl_outs: got lv %b st %b lw %b mode %b want all 0", load_valid, stall, stall_lw, data_bus_mode); end
    n_checks++; if ({fault_valid, fault_cause, fault_addr, data_bus_addr} !== 67'h0) begin n_errors++; $display("FAIL rdl_regs: got %b/%b/%h addr %h want 0", fault_valid, fault_cause, fault_addr, data_bus_addr); end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
      n_checks++; if (load_valid !== 1'b0 || data_bus_mode !== 2'b00) begin n_errors++; $display("FAIL rdl_post%0d: got %b/%b want 0/00", k, load_valid, data_bus_mode); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 32'h2FFF);
        1: a = 32'h2FFC + $urandom_range(0, 8);
        2: a = $urandom;
        default: a = $urandom_range(32'h3000, 32'hFFFF);
      endcase
      drive(($urandom_range(0, 9) < 6), $urandom_range(0, 1), a, $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 1), 5'($urandom_range(0, 31)), ($urandom_range(0, 9) == 0));
      n_checks++; if (data_bus_mode !== e_mode) begin n_errors++; $display("FAIL rnd_mode %0d: got %b want %b", i, data_bus_mode, e_mode); end
      n_checks++; if (data_bus_addr !== e_addr) begin n_errors++; $display("FAIL rnd_addr %0d: got %h want %h", i, data_bus_addr, e_addr); end
      n_checks++; if (data_bus_reqw !== e_reqw) begin n_errors++; $display("FAIL rnd_reqw %0d: got %b want %b", i, data_bus_reqw, e_reqw); end
      if (e_mode != MODE_WRITE) begin
        n_checks++; if (data_bus_reqs !== e_reqs) begin n_errors++; $display("FAIL rnd_reqs %0d: got %b want %b", i, data_bus_reqs, e_reqs); end
      end
      if (e_mode != MODE_READ) begin
        n_checks++; if (data_bus_data !== e_bus) begin n_errors++; $display("FAIL rnd_bus %0d: got %h want %h", i, data_bus_data, e_bus); end
      end
      n_checks++; if ({stall, stall_lw} !== {e_stall, e_stall_lw}) begin n_errors++; $display("FAIL rnd_stall %0d: got %b%b want %b%b", i, stall, stall_lw, e_stall, e_stall_lw); end
      n_checks++; if ({load_valid, load_rd, load_data} !== {e_lv, e_lrd, e_ld}) begin n_errors++; $display("FAIL rnd_load %0d: got %b/%0d/%h want %b/%0d/%h", i, load_valid, load_rd, load_data, e_lv, e_lrd, e_ld); end
      n_checks++; if ({fault_valid, fault_cause, fault_addr} !== {m_fv, m_fc, m_fa}) begin n_errors++; $display("FAIL rnd_fault %0d: got %b/%b/%h want %b/%b/%h", i, fault_valid, fault_cause, fault_addr, m_fv, m_fc, m_fa); end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_width = 2'b00; req_signed = 1'b0; req_rd = 5'd0; fault_clear = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    model_reset();
    test_reset();
    test_load_word();
    test_signed_byte();
    test_store();
    test_fault();
    test_back_to_back();
    test_reset_during_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
